// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects,
// memory-busy freeze, idle clock-gate request and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned IDLE_THRESH = 8,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wake,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             gate_req,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned IDLE_W = 8;
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    IDLE     = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_inc;
  logic                luse_q;
  logic                mem_busy;
  logic                redirect;
  logic                luse_raw;
  logic                load_use;
  logic                activity;
  logic                idle_hit;

  assign mem_busy = mem_req & ~mem_ready;
  assign redirect = ex_branch_taken | ex_jump;
  assign luse_raw = ex_mem_read & (ex_rd != 5'd0) & id_valid &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  // The bubble just inserted now sits in EX, so the same load never stalls twice.
  assign load_use = luse_raw & ~luse_q;
  assign activity = id_valid | mem_req | ex_branch_taken | ex_jump | wake;
  // Idle threshold is reached on the edge that takes idle_cnt to IDLE_THRESH.
  assign idle_hit = ~activity & ((32'(idle_cnt) + 32'd1) >= IDLE_THRESH);
  assign wait_inc = (wait_cnt == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
  assign state    = state_q;
  assign gate_req = ~rst & (state_q == IDLE) & ~activity;

  // Mealy pipeline controls in priority order: memory freeze, redirect, load-use.
  always_comb begin
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    if (!rst) begin
      if (mem_busy) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
      end else if (redirect) begin
        pc_sel      = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      idle_cnt    <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      luse_q      <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (activity)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(IDLE_THRESH))
        idle_cnt <= idle_cnt + IDLE_W'(1);

      case (state_q)
        RUN: begin
          if (mem_busy)      state_q <= MEM_WAIT;
          else if (idle_hit) state_q <= IDLE;
        end
        MEM_WAIT: if (!mem_busy) state_q <= RUN;
        IDLE: begin
          if (mem_busy)      state_q <= MEM_WAIT;
          else if (activity) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase

      if ((state_q == MEM_WAIT) && mem_busy) wait_cnt <= wait_inc;
      else                                    wait_cnt <= '0;
      if ((state_q == MEM_WAIT) && (wait_inc == WAIT_W'(MEM_TIMEOUT))) mem_timeout <= 1'b1;

      // Frozen cycles hold the bubble marker until the pipeline moves again.
      if (!mem_busy) luse_q <= load_use & ~redirect;

      if (cnt_clr)
        stall_cnt <= '0;
      else if ((mem_busy | (load_use & ~redirect)) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (cnt_clr)
        flush_cnt <= '0;
      else if (~mem_busy & redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, IDLE_THRESH=8).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, ex_branch_taken, ex_jump;
  logic        mem_req, mem_ready, wake, cnt_clr;
  logic        pc_write, pc_sel, if_id_write, if_id_flush;
  logic        id_ex_write, id_ex_flush, ex_mem_write;
  logic        gate_req, mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(.CNT_W(16), .IDLE_THRESH(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .wake(wake), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .pc_sel(pc_sel),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .gate_req(gate_req),
    .mem_timeout(mem_timeout), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_jump = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; wake = 1'b0; cnt_clr = 1'b0;
    #2;
    chk("rst_pc_write", pc_write === 1'b1, 32'(pc_write), 32'(1));
    chk("rst_if_id_write", if_id_write === 1'b1, 32'(if_id_write), 32'(1));
    chk("rst_id_ex_flush", id_ex_flush === 1'b0, 32'(id_ex_flush), 32'(0));
    chk("rst_gate_req", gate_req === 1'b0, 32'(gate_req), 32'(0));
    chk("rst_state", state === 2'd0, 32'(state), 32'(0));
    chk("rst_stall_cnt", stall_cnt === 16'd0, 32'(stall_cnt), 32'(0));
    chk("rst_flush_cnt", flush_cnt === 16'd0, 32'(flush_cnt), 32'(0));
    chk("rst_mem_timeout", mem_timeout === 1'b0, 32'(mem_timeout), 32'(0));
    step();
    rst = 1'b0;
    id_valid = 1'b1;

    // lw x5 in EX, add x6,x5,x1 in ID
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd1;
    #1;
    chk("lu_pc_write", pc_write === 1'b0, 32'(pc_write), 32'(0));
    chk("lu_if_id_write", if_id_write === 1'b0, 32'(if_id_write), 32'(0));
    chk("lu_id_ex_flush", id_ex_flush === 1'b1, 32'(id_ex_flush), 32'(1));
    chk("lu_id_ex_write", id_ex_write === 1'b1, 32'(id_ex_write), 32'(1));
    chk("lu_ex_mem_write", ex_mem_write === 1'b1, 32'(ex_mem_write), 32'(1));
    chk("lu_pc_sel", pc_sel === 1'b0, 32'(pc_sel), 32'(0));
    step();
    chk("lu_stall_cnt", stall_cnt === 16'd1, 32'(stall_cnt), 32'(1));
    // Same inputs next cycle: only one bubble per load.
    chk("lu_next_pc_write", pc_write === 1'b1, 32'(pc_write), 32'(1));
    chk("lu_next_if_id_write", if_id_write === 1'b1, 32'(if_id_write), 32'(1));
    chk("lu_next_id_ex_flush", id_ex_flush === 1'b0, 32'(id_ex_flush), 32'(0));
    step();
    chk("lu_next_stall_cnt", stall_cnt === 16'd1, 32'(stall_cnt), 32'(1));

    // Load to x0 with ID reading x0; also clear the counters.
    ex_rd = 5'd0; id_rs1 = 5'd0; cnt_clr = 1'b1;
    #1;
    chk("x0_pc_write", pc_write === 1'b1, 32'(pc_write), 32'(1));
    chk("x0_if_id_write", if_id_write === 1'b1, 32'(if_id_write), 32'(1));
    chk("x0_id_ex_flush", id_ex_flush === 1'b0, 32'(id_ex_flush), 32'(0));
    step();
    chk("clr_stall_cnt", stall_cnt === 16'd0, 32'(stall_cnt), 32'(0));
    cnt_clr = 1'b0;
    step();
    chk("x0_stall_cnt", stall_cnt === 16'd0, 32'(stall_cnt), 32'(0));

    // Taken branch with a simultaneous load-use match.
    ex_rd = 5'd5; id_rs1 = 5'd5; ex_branch_taken = 1'b1;
    #1;
    chk("br_pc_sel", pc_sel === 1'b1, 32'(pc_sel), 32'(1));
    chk("br_pc_write", pc_write === 1'b1, 32'(pc_write), 32'(1));
    chk("br_if_id_flush", if_id_flush === 1'b1, 32'(if_id_flush), 32'(1));
    chk("br_id_ex_flush", id_ex_flush === 1'b1, 32'(id_ex_flush), 32'(1));
    chk("br_if_id_write", if_id_write === 1'b1, 32'(if_id_write), 32'(1));
    step();
    chk("br_flush_cnt", flush_cnt === 16'd1, 32'(flush_cnt), 32'(1));
    chk("br_stall_cnt", stall_cnt === 16'd0, 32'(stall_cnt), 32'(0));
    ex_branch_taken = 1'b0; ex_mem_read = 1'b0;

    // JAL held in EX while memory is busy for 3 cycles.
    ex_jump = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("mw_pc_write", pc_write === 1'b0, 32'(pc_write), 32'(0));
      chk("mw_ex_mem_write", ex_mem_write === 1'b0, 32'(ex_mem_write), 32'(0));
      chk("mw_pc_sel", pc_sel === 1'b0, 32'(pc_sel), 32'(0));
      step();
      chk("mw_stall_cnt", stall_cnt === 16'(i), 32'(stall_cnt), 32'(i));
      chk("mw_state", state === 2'd1, 32'(state), 32'(1));
    end
    mem_ready = 1'b1;
    #1;
    chk("mw_rdy_pc_sel", pc_sel === 1'b1, 32'(pc_sel), 32'(1));
    chk("mw_rdy_if_id_flush", if_id_flush === 1'b1, 32'(if_id_flush), 32'(1));
    chk("mw_rdy_pc_write", pc_write === 1'b1, 32'(pc_write), 32'(1));
    step();
    chk("mw_rdy_state", state === 2'd0, 32'(state), 32'(0));
    chk("mw_rdy_flush_cnt", flush_cnt === 16'd2, 32'(flush_cnt), 32'(2));
    chk("mw_rdy_stall_cnt", stall_cnt === 16'd3, 32'(stall_cnt), 32'(3));
    ex_jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    step();

    // Memory timeout: 6 busy cycles, first is in RUN, then 5 in MEM_WAIT.
    mem_req = 1'b1;
    step();
    chk("to_state", state === 2'd1, 32'(state), 32'(1));
    step(); step(); step();
    chk("to_before", mem_timeout === 1'b0, 32'(mem_timeout), 32'(0));
    step();
    chk("to_set", mem_timeout === 1'b1, 32'(mem_timeout), 32'(1));
    step();
    chk("to_hold_wait", mem_timeout === 1'b1, 32'(mem_timeout), 32'(1));
    mem_ready = 1'b1;
    step();
    chk("to_exit_state", state === 2'd0, 32'(state), 32'(0));
    chk("to_sticky", mem_timeout === 1'b1, 32'(mem_timeout), 32'(1));
    mem_ready = 1'b0;
    step();
    chk("to_rewait_state", state === 2'd1, 32'(state), 32'(1));
    rst = 1'b1;
    #1;
    chk("to_rst_state", state === 2'd0, 32'(state), 32'(0));
    chk("to_rst_timeout", mem_timeout === 1'b0, 32'(mem_timeout), 32'(0));
    chk("to_rst_stall_cnt", stall_cnt === 16'd0, 32'(stall_cnt), 32'(0));
    chk("to_rst_pc_write", pc_write === 1'b1, 32'(pc_write), 32'(1));
    chk("to_rst_ex_mem_write", ex_mem_write === 1'b1, 32'(ex_mem_write), 32'(1));

    // Idle detection with all inputs low.
    mem_req = 1'b0; id_valid = 1'b0; id_uses_rs1 = 1'b0;
    step();
    rst = 1'b0;
    repeat (7) step();
    chk("idle7_state", state === 2'd0, 32'(state), 32'(0));
    chk("idle7_gate_req", gate_req === 1'b0, 32'(gate_req), 32'(0));
    step();
    chk("idle8_state", state === 2'd2, 32'(state), 32'(2));
    chk("idle8_gate_req", gate_req === 1'b1, 32'(gate_req), 32'(1));
    wake = 1'b1;
    #1;
    chk("wake_gate_req", gate_req === 1'b0, 32'(gate_req), 32'(0));
    chk("wake_state", state === 2'd2, 32'(state), 32'(2));
    step();
    chk("wake_next_state", state === 2'd0, 32'(state), 32'(0));
    wake = 1'b0;

    // Stall counter saturation via a long memory freeze.
    id_valid = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_fffd", stall_cnt === 16'hFFFD, 32'(stall_cnt), 32'(16'hFFFD));
    step();
    chk("sat_fffe", stall_cnt === 16'hFFFE, 32'(stall_cnt), 32'(16'hFFFE));
    step();
    chk("sat_ffff", stall_cnt === 16'hFFFF, 32'(stall_cnt), 32'(16'hFFFF));
    step(); step();
    chk("sat_hold", stall_cnt === 16'hFFFF, 32'(stall_cnt), 32'(16'hFFFF));
    cnt_clr = 1'b1;
    step();
    chk("sat_clr_stall", stall_cnt === 16'd0, 32'(stall_cnt), 32'(0));
    chk("sat_clr_flush", flush_cnt === 16'd0, 32'(flush_cnt), 32'(0));
    cnt_clr = 1'b0; mem_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
